// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: requester, clear-control and adapter write-port signals of the plot arbiter
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int COLOUR_BITS = 3,
  parameter int X_BITS      = 9,
  parameter int Y_BITS      = 8
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*X_BITS-1:0]      req_x;
  logic [NUM_REQ*Y_BITS-1:0]      req_y;
  logic [NUM_REQ*COLOUR_BITS-1:0] req_colour;
  logic [NUM_REQ-1:0]             ack;
  logic                           clear_start;
  logic [COLOUR_BITS-1:0]         clear_colour;
  logic                           clear_busy;
  logic                           clear_done;
  logic [X_BITS-1:0]              x;
  logic [Y_BITS-1:0]              y;
  logic [COLOUR_BITS-1:0]         colour;
  logic                           plot;
  modport master (
    output req, req_x, req_y, req_colour, clear_start, clear_colour,
    input  ack, clear_busy, clear_done, x, y, colour, plot
  );
  modport slave (
    input  req, req_x, req_y, req_colour, clear_start, clear_colour,
    output ack, clear_busy, clear_done, x, y, colour, plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin sharing of the VGA pixel port plus a full-screen clear sequencer
module vga_plot_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int COLOUR_BITS = 3,
  parameter int X_BITS      = 9,
  parameter int Y_BITS      = 8,
  parameter int X_MAX       = 320,
  parameter int Y_MAX       = 240
) (
  input logic clock,
  input logic reset,
  vga_plot_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic {ARB, CLEAR} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, win;
  logic found, arb_ok, done;
  logic [NUM_REQ-1:0] ack_c;
  logic [X_BITS-1:0] cx;
  logic [Y_BITS-1:0] cy;
  logic [COLOUR_BITS-1:0] fill;
  int idx;
  // search starts just after the last winner and wraps, giving round-robin order
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end
  always_comb begin
    arb_ok   = state == ARB && !bus.clear_start && found;
    ack_c    = '0;
    ack_c[win] = arb_ok;
    bus.ack  = ack_c;
    state_nx = state == ARB ? (bus.clear_start ? CLEAR : ARB) : (done ? ARB : CLEAR);
  end
  assign bus.clear_busy = state == CLEAR;
  assign bus.clear_done = done;
  // done marks the cycle the final fill pixel is visible; the fill ends one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      ptr        <= PW'(NUM_REQ - 1);
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      fill       <= '0;
      done       <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= 1'b0;
      bus.plot <= 1'b0;
      if (state == ARB) begin
        if (bus.clear_start) begin
          fill <= bus.clear_colour;
          cx   <= '0;
          cy   <= '0;
        end else if (found) begin
          bus.x      <= bus.req_x[int'(win)*X_BITS +: X_BITS];
          bus.y      <= bus.req_y[int'(win)*Y_BITS +: Y_BITS];
          bus.colour <= bus.req_colour[int'(win)*COLOUR_BITS +: COLOUR_BITS];
          bus.plot   <= 1'b1;
          ptr        <= win;
        end
      end else if (!done) begin
        bus.x      <= cx;
        bus.y      <= cy;
        bus.colour <= fill;
        bus.plot   <= 1'b1;
        if (cx == X_BITS'(X_MAX - 1)) begin
          cx <= '0;
          if (cy == Y_BITS'(Y_MAX - 1)) done <= 1'b1;
          else cy <= cy + Y_BITS'(1);
        end else cx <= cx + X_BITS'(1);
      end
    end
  end
endmodule
